add_sub_serial: RTL and testbench
=================================

# add_sub_serial

Parametrised multi-cycle adder/subtractor for the add_sub datapath. It processes a WIDTH-bit operand pair DIGIT bits per cycle through a ripple row of full adders, retiring one digit per clock. Operands enter and results leave through valid/ready handshakes. It returns the sum or difference with carry, signed-overflow and zero flags, and trades latency for adder area in wide datapaths.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- STEPS (localparam) = WIDTH/DIGIT, the number of compute cycles.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  an operand pair is presented.
- in_ready  out  1  the block can accept an operand pair.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand.
- sub  in  1  0 = a+b, 1 = a−b; sampled with the operands.
- out_valid  out  1  the result and flags are valid.
- out_ready  in  1  the consumer accepts the result.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- carry  out  1  carry out of the MSB; for subtraction, 1 = no borrow (a ≥ b unsigned).
- overflow  out  1  two's-complement overflow.
- zero  out  1  result == 0.

## Operation
State machine: IDLE → RUN → DONE → IDLE.

IDLE:
- in_ready=1, out_valid=0.
- On in_valid: capture a into acc_a and (b XOR {WIDTH{sub}}) into acc_b.
- Set the carry register to sub, clear the step counter, and go to RUN.

RUN:
- in_ready=0.
- Each cycle, add the low DIGIT bits of acc_a and acc_b plus the carry register.
- Shift acc_a and acc_b right by DIGIT.
- Shift the DIGIT sum bits into the top of the result register.
- The carry register takes the digit carry-out. Increment the counter.
- On the cycle the counter equals STEPS−1:
  - latch overflow = (carry into the digit's MSB) XOR (digit carry-out);
  - latch carry = digit carry-out;
  - go to DONE.

DONE:
- out_valid=1.
- result, carry, overflow and zero are held stable until out_ready=1, then go to IDLE.

Flags:
- zero is registered, computed from the final result when entering DONE.

Boundary rules:
- No operand is accepted in DONE. Back-to-back throughput is one operation per STEPS+2 cycles.
- in_valid while in RUN or DONE is ignored; the operands are not captured.
- After handshake, result and the flags keep their last values; only out_valid drops.
- DIGIT=WIDTH: STEPS=1, so RUN lasts exactly one cycle.
- DIGIT=1: the carry into the MSB is the carry register at the final step.

Reset:
- rst=1 at any edge (including mid-RUN or in DONE) forces IDLE.
- Reset clears the step counter, the operand/result registers and every output register.
- Any in-flight operation is discarded.

## Timing
- Reset values: in_ready=1 (combinational from IDLE), out_valid=0, result=0, carry=0, overflow=0, zero=0.
- Accept edge T (in_valid & in_ready): the RUN edges are T+1 … T+STEPS, and out_valid=1 from after edge T+STEPS.
- Latency from accept to out_valid is STEPS cycles.
- Output handshake at edge U (out_valid & out_ready): in_ready=1 after U, and the next accept is possible at edge U+1.
- Ready/valid outputs are decoded from registered state only; there is no combinational path from in_valid or out_ready to any output.

## Structure
- Package add_sub_pkg: the state enum (IDLE, RUN, DONE) and a WIDTH-of-counter helper function ($clog2(STEPS), minimum 1).
- Sub-module add_digit, parameter DIGIT: a ripple chain of the existing fa cells.
  - Inputs: x, y (DIGIT bits) and cin.
  - Outputs: s (DIGIT bits), cout, and c_msb (the carry into bit DIGIT−1).
- add_sub_serial instantiates one add_digit and owns the FSM, the shift registers, the counter and the flag registers.

## Test plan
All cases use WIDTH=16, DIGIT=4 unless a case states otherwise.
1. Add 0x1234 + 0x0FCC → result=0x2200, carry=0, overflow=0, zero=0; out_valid rises exactly 4 cycles after the accept edge.
2. Add 0x7FFF + 0x0001 → 0x8000 with overflow=1, carry=0. Add 0xFFFF + 0x0001 → 0x0000 with carry=1, zero=1, overflow=0.
3. Subtract 0x0005 − 0x0005 → 0x0000 with zero=1, carry=1. Subtract 0x0000 − 0x0001 → 0xFFFF with carry=0, overflow=0. Subtract 0x8000 − 0x0001 → 0x7FFF with overflow=1.
4. Backpressure: hold out_ready=0 for 3 cycles in DONE → result and flags stay stable and in_ready=0. Pulse in_valid during that window → the operands are ignored. After handshake, the next operation is accepted at edge U+1.
5. Assert rst mid-RUN (step 2 of 4) → IDLE next cycle with out_valid=0 and all outputs 0. A following operation 0x0001+0x0001 → 0x0002.
6. Parameter sweep, DIGIT ∈ {1, 4, 16} with 1000 random operand pairs and modes each → results match a reference model. Latency equals 16, 4 and 1 cycles respectively.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package add_sub_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Step-counter width; never narrower than one bit so STEPS=1 still has a counter.
   function automatic int cnt_w(input int steps);
      return (steps <= 1) ? 1 : $clog2(steps);
   endfunction

endpackage

// File: rtl/add_sub_serial_add_digit.sv
// One digit of ripple-carry addition; exposes the carry into the MSB for overflow detection.
module add_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout,
   output logic             c_msb
);

   logic [DIGIT:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_bit
      fa u_fa (
         .x    (x[i]),
         .y    (y[i]),
         .cin  (c[i]),
         .s    (s[i]),
         .cout (c[i+1])
      );
   end

   assign cout  = c[DIGIT];
   assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/fa.sv
// Single-bit full adder cell.
module fa (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/add_sub_serial.sv
// Multi-cycle adder/subtractor: one DIGIT-bit slice per clock, valid/ready on both sides.
module add_sub_serial
   import add_sub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = cnt_w(STEPS);

   state_t           state;
   logic [WIDTH-1:0] acc_a, acc_b, res, res_nxt;
   logic             cy;
   logic [CW-1:0]    cnt;
   logic [DIGIT-1:0] s;
   logic             cout, c_msb;
   logic             last;

   add_digit #(.DIGIT(DIGIT)) u_digit (
      .x     (acc_a[DIGIT-1:0]),
      .y     (acc_b[DIGIT-1:0]),
      .cin   (cy),
      .s     (s),
      .cout  (cout),
      .c_msb (c_msb)
   );

   // Sum digits enter at the top so the final slice lands in the MSBs.
   if (DIGIT == WIDTH) begin : g_full
      assign res_nxt = s;
   end else begin : g_part
      assign res_nxt = {s, res[WIDTH-1:DIGIT]};
   end

   assign last     = (cnt == CW'(STEPS - 1));
   assign in_ready = (state == IDLE);
   assign result   = res;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc_a     <= '0;
         acc_b     <= '0;
         res       <= '0;
         cy        <= 1'b0;
         cnt       <= '0;
         out_valid <= 1'b0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc_a <= a;
                  acc_b <= b ^ {WIDTH{sub}};
                  cy    <= sub;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               acc_a <= acc_a >> DIGIT;
               acc_b <= acc_b >> DIGIT;
               res   <= res_nxt;
               cy    <= cout;
               cnt   <= cnt + 1'b1;
               if (last) begin
                  overflow  <= c_msb ^ cout;
                  carry     <= cout;
                  zero      <= (res_nxt == '0);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_add_sub_serial.sv
// Scoreboard bench for add_sub_serial at DIGIT = 1, 4 and 16 (WIDTH = 16).
module tb_add_sub_serial;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  in_valid, in_ready, out_valid, out_ready, sub, carry, overflow, zero;
   logic [15:0] a [3];
   logic [15:0] b [3];
   logic [15:0] result [3];

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] r;
      logic        c;
      logic        v;
      logic        z;
   } exp_t;

   exp_t sbq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      add_sub_serial #(
         .WIDTH (16),
         .DIGIT ((g == 0) ? 1 : (g == 1) ? 4 : 16)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .a         (a[g]),
         .b         (b[g]),
         .sub       (sub[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .result    (result[g]),
         .carry     (carry[g]),
         .overflow  (overflow[g]),
         .zero      (zero[g])
      );
   end

   function automatic int dg(input int k);
      return (k == 0) ? 1 : (k == 1) ? 4 : 16;
   endfunction

   // Reference: wide add, signed overflow from operand/result signs.
   function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
      exp_t        e;
      logic [16:0] w;
      w   = s ? ({1'b0, x} + {1'b0, ~y} + 17'd1) : ({1'b0, x} + {1'b0, y});
      e.r = w[15:0];
      e.c = w[16];
      e.v = s ? ((x[15] != y[15]) && (w[15] != x[15]))
              : ((x[15] == y[15]) && (w[15] != x[15]));
      e.z = (w[15:0] == 16'd0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Drive one operation, wait for the result, optionally stall the consumer for hold cycles.
   task automatic run_op(input int k, input logic [15:0] x, input logic [15:0] y,
                         input logic s, input int hold, input bit pulse);
      exp_t        e;
      int          n;
      int          t_acc;
      logic [15:0] r0;
      chk("in_ready_at_issue", in_ready[k], 1);
      a[k] = x; b[k] = y; sub[k] = s; in_valid[k] = 1'b1;
      sbq.push_back(model(x, y, s));
      t_acc = cyc + 1;
      @(negedge clk);
      in_valid[k] = 1'b0;
      a[k] = 16'($urandom); b[k] = 16'($urandom); sub[k] = 1'($urandom);
      n = 0;
      while (!out_valid[k] && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("out_valid_wait", out_valid[k], 1);
      chk("latency", cyc - t_acc, 16 / dg(k));
      e = sbq.pop_front();
      chk("result", result[k], e.r);
      chk("carry", carry[k], e.c);
      chk("overflow", overflow[k], e.v);
      chk("zero", zero[k], e.z);
      r0 = result[k];
      for (int i = 0; i < hold; i++) begin
         if (pulse) begin
            in_valid[k] = 1'b1; a[k] = 16'h1111; b[k] = 16'h2222; sub[k] = 1'b0;
         end
         @(negedge clk);
         chk("hold_valid", out_valid[k], 1);
         chk("hold_ready", in_ready[k], 0);
         chk("hold_result", result[k], r0);
         chk("hold_flags", {carry[k], overflow[k], zero[k]}, {e.c, e.v, e.z});
      end
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b1;
      @(negedge clk);
      out_ready[k] = 1'b0;
      chk("post_hs_valid", out_valid[k], 0);
      chk("post_hs_ready", in_ready[k], 1);
      chk("post_hs_result", result[k], e.r);
      chk("post_hs_flags", {carry[k], overflow[k], zero[k]}, {e.c, e.v, e.z});
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] x, y;
      rst = 1'b1;
      in_valid = '0; out_ready = '0; sub = '0;
      for (int k = 0; k < 3; k++) begin a[k] = '0; b[k] = '0; end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_in_ready", in_ready[k], 1);
         chk("rst_out_valid", out_valid[k], 0);
         chk("rst_result", result[k], 0);
         chk("rst_flags", {carry[k], overflow[k], zero[k]}, 3'b000);
      end
      rst = 1'b0;
      @(negedge clk);

      // Directed cases on DIGIT=4
      run_op(1, 16'h1234, 16'h0FCC, 1'b0, 0, 1'b0);
      run_op(1, 16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
      run_op(1, 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
      run_op(1, 16'h0005, 16'h0005, 1'b1, 0, 1'b0);
      run_op(1, 16'h0000, 16'h0001, 1'b1, 0, 1'b0);
      // Backpressure with ignored operands, then immediate next accept
      run_op(1, 16'hA5A5, 16'h1234, 1'b1, 3, 1'b1);
      run_op(1, 16'h8000, 16'h0001, 1'b1, 0, 1'b0);

      // Reset in the middle of RUN after two digit steps
      a[1] = 16'h4321; b[1] = 16'h1111; sub[1] = 1'b0; in_valid[1] = 1'b1;
      @(negedge clk);
      in_valid[1] = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrun_rst_valid", out_valid[1], 0);
      chk("midrun_rst_ready", in_ready[1], 1);
      chk("midrun_rst_result", result[1], 0);
      chk("midrun_rst_flags", {carry[1], overflow[1], zero[1]}, 3'b000);
      repeat (6) @(negedge clk);
      chk("midrun_rst_stays_idle", out_valid[1], 0);
      run_op(1, 16'h0001, 16'h0001, 1'b0, 0, 1'b0);

      // Random sweep per digit width, with corners at the start
      for (int k = 0; k < 3; k++) begin
         run_op(k, 16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
         run_op(k, 16'h8000, 16'h0001, 1'b1, 0, 1'b0);
         run_op(k, 16'hFFFF, 16'h0001, 1'b0, 1, 1'b1);
         for (int i = 0; i < 1000; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            run_op(k, x, y, 1'($urandom), 0, 1'b0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
